joystick_poll_ctrl: RTL and testbench

JOYSTICK_POLL_CTRL -- requirements
Module: joystick_poll_ctrl

---
 rtl/joystick_pkg.sv | 22 ++
 rtl/joystick_poll_ctrl_timer.sv | 27 ++
 rtl/joystick_poll_ctrl.sv | 165 ++++++++++++++++
 tb/tb_joystick_poll_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joystick_pkg.sv
// Shared definitions for the joystick poll controller: FSM encoding,
// frame length and the fixed command/centre constants.
package joystick_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        GAP,
        DONE
    } state_t;

    localparam int NUM_BYTES = 5;
    localparam logic [5:0] LED_PREFIX = 6'b100000;
    localparam logic [9:0] CENTRE = 10'd512;

    function automatic logic [9:0] join_axis(input logic [1:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/joystick_poll_ctrl_timer.sv
// Free-running period counter; tick is high while the count sits at
// its terminal value, after which it wraps to zero.
module poll_timer #(
    parameter int PERIOD = 1000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [W-1:0] count;

    assign tick = (count == W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/joystick_poll_ctrl.sv
// Periodically reads a 5-byte joystick frame over a byte-level SPI
// master and publishes X/Y/buttons once the whole frame has arrived.
module joystick_poll_ctrl
    import joystick_pkg::*;
#(
    parameter int POLL_PERIOD = 1000000,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] led,
    input  logic       spi_busy,
    input  logic       spi_done,
    input  logic [7:0] spi_rx_byte,
    output logic       spi_start,
    output logic [7:0] spi_tx_byte,
    output logic       ss,
    output logic [9:0] data_x,
    output logic [9:0] data_y,
    output logic [2:0] buttons,
    output logic       data_valid,
    output logic       error,
    output logic       overrun
);

    localparam int MAX_AB = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int MAXC   = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
    localparam int CW     = $clog2(MAXC + 1);
    localparam logic [2:0] LAST = 3'(NUM_BYTES - 1);

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] idx, idx_nx;
    logic tick;
    logic capture;
    logic publish;
    logic abort;

    // Only the bits that reach an output are kept from each byte.
    logic [7:0] sh_x_lo;
    logic [1:0] sh_x_hi;
    logic [7:0] sh_y_lo;
    logic [1:0] sh_y_hi;

    poll_timer #(
        .PERIOD(POLL_PERIOD)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign ss         = (state == IDLE) || (state == DONE);
    assign data_valid = (state == DONE);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = idx;
        spi_start   = 1'b0;
        spi_tx_byte = 8'h00;
        capture     = 1'b0;
        publish     = 1'b0;
        abort       = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_nx = SETUP;
                    idx_nx   = '0;
                    cnt_nx   = CW'(SS_SETUP - 1);
                end
            end
            SETUP, GAP: begin
                if (cnt == '0) begin
                    state_nx = START;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            START: begin
                if (!spi_busy) begin
                    spi_start = 1'b1;
                    if (idx == '0) begin
                        spi_tx_byte = {LED_PREFIX, led};
                    end
                    cnt_nx   = CW'(TIMEOUT - 1);
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (spi_done) begin
                    capture = 1'b1;
                    if (idx == LAST) begin
                        publish  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx + 3'd1;
                        cnt_nx   = CW'(BYTE_GAP - 1);
                        state_nx = GAP;
                    end
                end else if (cnt == '0) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh_x_lo <= '0;
            sh_x_hi <= '0;
            sh_y_lo <= '0;
            sh_y_hi <= '0;
            data_x  <= CENTRE;
            data_y  <= CENTRE;
            buttons <= '0;
            error   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            if (capture && !publish) begin
                case (idx)
                    3'd0:    sh_x_lo <= spi_rx_byte;
                    3'd1:    sh_x_hi <= spi_rx_byte[1:0];
                    3'd2:    sh_y_lo <= spi_rx_byte;
                    3'd3:    sh_y_hi <= spi_rx_byte[1:0];
                    default: ;
                endcase
            end
            // The last byte feeds the outputs directly so they land with data_valid.
            if (publish) begin
                data_x  <= join_axis(sh_x_hi, sh_x_lo);
                data_y  <= join_axis(sh_y_hi, sh_y_lo);
                buttons <= spi_rx_byte[2:0];
            end
            if (abort) begin
                error   <= 1'b1;
                sh_x_lo <= '0;
                sh_x_hi <= '0;
                sh_y_lo <= '0;
                sh_y_hi <= '0;
            end
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_joystick_poll_ctrl.sv
// Scoreboard bench: a byte responder feeds random frames, the expected
// reading is queued per frame and a monitor checks each data_valid.
module tb_joystick_poll_ctrl;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] b;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] led;
    logic       spi_busy;
    logic       spi_done;
    logic [7:0] spi_rx_byte;
    logic       spi_start;
    logic [7:0] spi_tx_byte;
    logic       ss;
    logic [9:0] data_x;
    logic [9:0] data_y;
    logic [2:0] buttons;
    logic       data_valid;
    logic       error;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_starts = 0;
    int first_start = -1;
    int start_cyc[5];
    int resp_delay = 2;
    int silent = -1;
    bit fixed_mode = 0;
    bit seen3 = 0;
    logic [7:0] rb[5];
    logic [7:0] fixed_b[5];
    logic [9:0] last_x = 10'd512;
    logic [9:0] last_y = 10'd512;
    logic [2:0] last_b = 3'd0;
    exp_t exp_q[$];

    joystick_poll_ctrl #(
        .POLL_PERIOD(100),
        .SS_SETUP   (4),
        .BYTE_GAP   (3),
        .TIMEOUT    (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .led        (led),
        .spi_busy   (spi_busy),
        .spi_done   (spi_done),
        .spi_rx_byte(spi_rx_byte),
        .spi_start  (spi_start),
        .spi_tx_byte(spi_tx_byte),
        .ss         (ss),
        .data_x     (data_x),
        .data_y     (data_y),
        .buttons    (buttons),
        .data_valid (data_valid),
        .error      (error),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2, input logic [7:0] b3,
                                   input logic [7:0] b4);
        exp_t e;
        e.x = 10'((int'(b1) % 4) * 256 + int'(b0));
        e.y = 10'((int'(b3) % 4) * 256 + int'(b2));
        e.b = 3'(int'(b4) % 8);
        return e;
    endfunction

    // Byte responder: answers resp_delay cycles after each spi_start.
    initial begin
        int idx;
        idx = 0;
        spi_busy = 1'b0;
        spi_done = 1'b0;
        spi_rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (ss) idx = 0;
            if (rst && spi_start) begin
                if (first_start < 0) first_start = cyc;
                start_cyc[idx] = cyc;
                n_starts++;
                if (idx == 3) seen3 = 1;
                chk("tx_byte", 32'(spi_tx_byte), (idx == 0) ? 32'(8'h80 | 8'(led)) : 32'h0);
                if (idx == 0) begin
                    for (int i = 0; i < 5; i++) rb[i] = fixed_mode ? fixed_b[i] : 8'($urandom);
                end
                @(posedge clk);
                #1;
                chk("start_one_cycle", 32'(spi_start), 32'h0);
                if (idx != silent) begin
                    spi_busy = 1'b1;
                    repeat (resp_delay - 1) @(posedge clk);
                    #1;
                    spi_done = 1'b1;
                    spi_rx_byte = rb[idx];
                    if (idx == 4) exp_q.push_back(model(rb[0], rb[1], rb[2], rb[3], rb[4]));
                    @(posedge clk);
                    #1;
                    spi_done = 1'b0;
                    spi_busy = 1'b0;
                    spi_rx_byte = 8'h00;
                end
                idx++;
            end
        end
    end

    // Monitor: pops an expected reading on every data_valid.
    initial begin
        exp_t e;
        logic [9:0] px, py;
        logic [2:0] pb;
        logic rst_q, dv_q;
        px = 10'd512; py = 10'd512; pb = 3'd0; rst_q = 1'b0; dv_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && data_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(data_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_x", 32'(data_x), 32'(e.x));
                    chk("data_y", 32'(data_y), 32'(e.y));
                    chk("buttons", 32'(buttons), 32'(e.b));
                    chk("ss_at_valid", 32'(ss), 32'h1);
                end
                last_x = data_x; last_y = data_y; last_b = buttons;
            end
            if (rst && rst_q && !data_valid &&
                (data_x !== px || data_y !== py || buttons !== pb))
                chk("stable_outputs", {12'h0, data_x, data_y}, {12'h0, px, py});
            if (data_valid && dv_q) chk("valid_pulse_width", 32'(dv_q), 32'h0);
            px = data_x; py = data_y; pb = buttons;
            rst_q = rst; dv_q = data_valid;
        end
    end

    task automatic wait_valid(input string name, input int budget);
        int n0;
        int k;
        n0 = n_valid;
        k = 0;
        while (n_valid == n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_valid == n0) chk(name, 32'h0, 32'h1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ss"}, 32'(ss), 32'h1);
        chk({tag, "_start"}, 32'(spi_start), 32'h0);
        chk({tag, "_tx"}, 32'(spi_tx_byte), 32'h0);
        chk({tag, "_x"}, 32'(data_x), 32'd512);
        chk({tag, "_y"}, 32'(data_y), 32'd512);
        chk({tag, "_btn"}, 32'(buttons), 32'h0);
        chk({tag, "_valid"}, 32'(data_valid), 32'h0);
        chk({tag, "_error"}, 32'(error), 32'h0);
        chk({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    initial begin
        int rel;
        int k;
        int s0;
        rst = 1'b0;
        led = 2'b10;
        fixed_b[0] = 8'h2C; fixed_b[1] = 8'h03; fixed_b[2] = 8'h90;
        fixed_b[3] = 8'h01; fixed_b[4] = 8'h05;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        fixed_mode = 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rel = cyc;

        k = 0;
        while (first_start < 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("first_start_cycle", 32'(first_start - rel), 32'd104);
        chk("centre_x_before_valid", 32'(data_x), 32'd512);
        chk("centre_y_before_valid", 32'(data_y), 32'd512);
        wait_valid("fixed_valid_timeout", 200);
        chk("fixed_x", 32'(last_x), 32'h32C);
        chk("fixed_y", 32'(last_y), 32'h190);
        chk("fixed_btn", 32'(last_b), 32'h5);
        fixed_mode = 0;

        repeat (5) begin
            led = 2'($urandom);
            wait_valid("random_valid_timeout", 250);
        end

        // spi_busy held high from slave-select fall for 20 cycles
        k = 0;
        while (ss && k < 250) begin
            @(negedge clk);
            k++;
        end
        chk("busy_ss_fall", 32'(ss), 32'h0);
        spi_busy = 1'b1;
        s0 = n_starts;
        repeat (20) begin
            @(negedge clk);
            chk("start_while_busy", 32'(spi_start), 32'h0);
        end
        @(posedge clk);
        #1;
        spi_busy = 1'b0;
        wait_valid("busy_valid_timeout", 100);
        chk("busy_start_count", 32'(n_starts - s0), 32'd5);

        // byte 2 never answered
        chk("error_before_timeout", 32'(error), 32'h0);
        silent = 2;
        k = 0;
        while (!error && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_error", 32'(error), 32'h1);
        chk("timeout_latency", 32'(cyc - start_cyc[2]), 32'd51);
        chk("timeout_ss_high", 32'(ss), 32'h1);
        chk("timeout_x_kept", 32'(data_x), 32'(last_x));
        chk("timeout_y_kept", 32'(data_y), 32'(last_y));
        silent = -1;

        // slow responder stretches one poll past the period
        chk("overrun_before", 32'(overrun), 32'h0);
        resp_delay = 30;
        wait_valid("slow_valid_timeout", 400);
        chk("overrun_set", 32'(overrun), 32'h1);
        resp_delay = 2;
        led = 2'($urandom);
        wait_valid("after_overrun_timeout", 250);

        // reset while byte 3 is outstanding
        seen3 = 0;
        k = 0;
        while (!seen3 && k < 250) begin
            @(negedge clk);
            k++;
        end
        chk("reached_byte3", 32'(seen3), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("midpoll");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) begin
            led = 2'($urandom);
            wait_valid("post_reset_timeout", 250);
        end
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
